// File: rtl/ex_stage_if.sv
//------------------------------------------------------------------------------
// ex_stage_if : decode/memory-side signal bundle of the execute stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ex_stage_if;
  logic [5:0]   stall;
  logic [145:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [38:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// ex_stage : pipeline execute stage - ALU, data-SRAM request, radix-2 divider
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage (
  input  wire logic clk,
  input  wire logic rst,
  ex_stage_if.slave bus
);

  localparam logic c_STOP   = 1'b1;
  localparam logic c_NOSTOP = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // ID->EX register
  logic [145:0] r_id_ex;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_ex <= '0;
    end else if (bus.stall[2] == c_STOP && bus.stall[3] == c_NOSTOP) begin
      r_id_ex <= '0;
    end else if (bus.stall[2] == c_NOSTOP) begin
      r_id_ex <= bus.id_to_ex_bus;
    end
  end

  logic [31:0] w_pc;
  logic [3:0]  w_alu_op;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [1:0]  w_md_op;
  logic        w_md_rem;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [1:0]  w_mem_size;
  logic [31:0] w_st_data;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;

  assign w_pc         = r_id_ex[145:114];
  assign w_alu_op     = r_id_ex[113:110];
  assign w_src_a      = r_id_ex[109:78];
  assign w_src_b      = r_id_ex[77:46];
  assign w_md_op      = r_id_ex[45:44];
  assign w_md_rem     = r_id_ex[43];
  assign w_mem_en     = r_id_ex[42];
  assign w_mem_we     = r_id_ex[41];
  assign w_mem_size   = r_id_ex[40:39];
  assign w_st_data    = r_id_ex[38:7];
  assign w_sel_rf_res = r_id_ex[6];
  assign w_rf_we      = r_id_ex[5];
  assign w_rf_waddr   = r_id_ex[4:0];

  // ALU
  logic [31:0] w_alu_res;
  logic [4:0]  w_shamt;

  assign w_shamt = w_src_a[4:0];

  always_comb begin
    w_alu_res = 32'd0;
    case (w_alu_op)
      4'd0:    w_alu_res = w_src_a + w_src_b;
      4'd1:    w_alu_res = w_src_a - w_src_b;
      4'd2:    w_alu_res = w_src_a & w_src_b;
      4'd3:    w_alu_res = w_src_a | w_src_b;
      4'd4:    w_alu_res = w_src_a ^ w_src_b;
      4'd5:    w_alu_res = ~(w_src_a | w_src_b);
      4'd6:    w_alu_res = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      4'd7:    w_alu_res = {31'd0, w_src_a < w_src_b};
      4'd8:    w_alu_res = w_src_b << w_shamt;
      4'd9:    w_alu_res = w_src_b >> w_shamt;
      4'd10:   w_alu_res = $unsigned($signed(w_src_b) >>> w_shamt);
      4'd11:   w_alu_res = {w_src_b[15:0], 16'd0};
      4'd12:   w_alu_res = w_src_a;
      default: w_alu_res = 32'd0;
    endcase
  end

  // Memory request
  logic [31:0] w_addr;
  logic [3:0]  w_wen;
  logic [31:0] w_wdata;

  assign w_addr = w_src_a + w_src_b;

  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = 32'd0;
    if (w_mem_en && w_mem_we) begin
      case (w_mem_size)
        2'b00: begin
          w_wen   = 4'b0001 << w_addr[1:0];
          w_wdata = {4{w_st_data[7:0]}};
        end
        2'b01: begin
          w_wen   = w_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{w_st_data[15:0]}};
        end
        2'b10: begin
          w_wen   = 4'b1111;
          w_wdata = w_st_data;
        end
        default: begin
          w_wen   = 4'b0000;
          w_wdata = 32'd0;
        end
      endcase
    end
  end

  // Divider
  div_state_t  r_state;
  div_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;

  logic        w_md_active;
  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_md_active = (w_md_op != 2'b00);
  assign w_signed    = (w_md_op == 2'b01);
  assign w_abs_a     = (w_signed && w_src_a[31]) ? (32'd0 - w_src_a) : w_src_a;
  assign w_abs_b     = (w_signed && w_src_b[31]) ? (32'd0 - w_src_b) : w_src_b;
  assign w_shift     = {r_rem, r_quot[31]};
  assign w_diff      = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_md_active) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  if (bus.stall[3] == c_NOSTOP) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Restoring shift-subtract: one quotient bit per BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 5'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_md_active) begin
        r_cnt      <= 5'd0;
        r_quot     <= w_abs_a;
        r_rem      <= 32'd0;
        r_divisor  <= w_abs_b;
        r_neg_q    <= w_signed && (w_src_a[31] ^ w_src_b[31]);
        r_neg_r    <= w_signed && w_src_a[31];
        r_div_zero <= (w_src_b == 32'd0);
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem  <= w_diff[31:0];
        r_quot <= {r_quot[30:0], 1'b1};
      end else begin
        r_rem  <= w_shift[31:0];
        r_quot <= {r_quot[30:0], 1'b0};
      end
    end
  end

  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_div_res;

  assign w_q_fix = r_div_zero ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quot) : r_quot);
  assign w_r_fix = r_div_zero ? w_src_a       : (r_neg_r ? (32'd0 - r_rem)  : r_rem);
  assign w_div_res = (r_state == S_DONE) ? (w_md_rem ? w_r_fix : w_q_fix) : 32'd0;

  // Result select and outputs
  logic [31:0] w_ex_result;

  assign w_ex_result = w_mem_en    ? w_addr    :
                       w_md_active ? w_div_res : w_alu_res;

  assign bus.data_sram_en    = w_mem_en;
  assign bus.data_sram_wen   = w_wen;
  assign bus.data_sram_addr  = {w_addr[31:2], 2'b00};
  assign bus.data_sram_wdata = w_wdata;
  assign bus.stallreq_for_ex = w_md_active && (r_state != S_DONE);

  assign bus.ex_to_mem_bus = {w_pc, w_mem_en, w_wen, w_sel_rf_res, w_rf_we,
                              w_rf_waddr, w_ex_result};
  assign bus.ex_to_id_bus  = {w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//------------------------------------------------------------------------------
// tb_ex_stage : directed self-checking bench for ex_stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ex_stage_if u_if ();

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [145:0] mk(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [1:0] md,
                                      input logic rem, input logic men, input logic mwe,
                                      input logic [1:0] sz, input logic [31:0] st);
    return {32'h0000_0100, op, a, b, md, rem, men, mwe, sz, st, 1'b0, 1'b1, 5'd7};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [145:0] b);
    u_if.id_to_ex_bus = b;
    u_if.stall        = 6'b000000;
    step();
  endtask

  // Emulates the stall controller while the divider is busy
  task automatic run_div(input string tag, input logic [145:0] b, input logic [31:0] exp);
    int n;
    load(b);
    n = 0;
    while (u_if.stallreq_for_ex && n < 100) begin
      n++;
      u_if.stall = 6'b001111;
      step();
    end
    check({tag, " stall cycles"}, 76'(n), 76'd33);
    check({tag, " result"}, 76'(u_if.ex_to_mem_bus[31:0]), 76'(exp));
    check({tag, " fwd"}, 76'(u_if.ex_to_id_bus[31:0]), 76'(exp));
  endtask

  initial begin
    logic [159:0] rnd;
    n_tests = 0;
    n_fail  = 0;

    // Reset with random inputs
    rst = 1'b0;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    u_if.id_to_ex_bus = rnd[145:0];
    u_if.stall        = 6'($urandom);
    step();
    step();
    check("rst mem_bus", 76'(u_if.ex_to_mem_bus), 76'd0);
    check("rst id_bus",  76'(u_if.ex_to_id_bus), 76'd0);
    check("rst sram", 76'({u_if.data_sram_en, u_if.data_sram_wen,
                           u_if.data_sram_addr, u_if.data_sram_wdata}), 76'd0);
    check("rst stallreq", 76'(u_if.stallreq_for_ex), 76'd0);

    // First op after release appears next cycle
    u_if.stall = 6'b000000;
    u_if.id_to_ex_bus = mk(4'd0, 32'd3, 32'd5, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("add full bus", u_if.ex_to_mem_bus,
          {32'h0000_0100, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd7, 32'd8});
    check("add id bus", 76'(u_if.ex_to_id_bus), 76'({1'b0, 1'b1, 5'd7, 32'd8}));

    // ALU sweep
    load(mk(4'd1, 32'd3, 32'd5, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("sub", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFE));
    load(mk(4'd6, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("slt", 76'(u_if.ex_to_mem_bus[31:0]), 76'd1);
    load(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("sltu", 76'(u_if.ex_to_mem_bus[31:0]), 76'd0);
    load(mk(4'd10, 32'd4, 32'h8000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("sra", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'hF800_0000));
    load(mk(4'd9, 32'd4, 32'h8000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("srl", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'h0800_0000));
    load(mk(4'd11, 32'd0, 32'h0000_1234, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("lui", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'h1234_0000));
    load(mk(4'd5, 32'h0F0F_0000, 32'h0000_00F0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("nor", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'hF0F0_FF0F));
    load(mk(4'd14, 32'd9, 32'd9, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("op14 zero", 76'(u_if.ex_to_mem_bus[31:0]), 76'd0);

    // Stores and loads
    load(mk(4'd0, 32'h1000, 32'd3, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_00AB));
    check("sb wen", 76'(u_if.data_sram_wen), 76'(4'b1000));
    check("sb wdata", 76'(u_if.data_sram_wdata), 76'(32'hABAB_ABAB));
    check("sb addr", 76'(u_if.data_sram_addr), 76'(32'h0000_1000));
    check("sb bus en/wen", 76'(u_if.ex_to_mem_bus[43:39]), 76'(5'b11000));
    load(mk(4'd0, 32'h1000, 32'd2, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_BEEF));
    check("sh hi wen", 76'(u_if.data_sram_wen), 76'(4'b1100));
    check("sh wdata", 76'(u_if.data_sram_wdata), 76'(32'hBEEF_BEEF));
    load(mk(4'd0, 32'h1000, 32'd1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_BEEF));
    check("sh lo wen", 76'(u_if.data_sram_wen), 76'(4'b0011));
    load(mk(4'd0, 32'h1000, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 32'h1234_5678));
    check("sw wen", 76'(u_if.data_sram_wen), 76'(4'b1111));
    check("sw wdata", 76'(u_if.data_sram_wdata), 76'(32'h1234_5678));
    load(mk(4'd1, 32'h1000, 32'd3, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_00AB));
    check("lw wen", 76'(u_if.data_sram_wen), 76'd0);
    check("lw en", 76'(u_if.data_sram_en), 76'd1);
    check("lw result", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'h0000_1003));

    // Divides, issued back to back
    run_div("div q", mk(4'd0, 32'hFFFF_FFF9, 32'd2, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0),
            32'hFFFF_FFFD);
    // Hold DONE while EX is stalled
    u_if.stall = 6'b001111;
    step();
    check("div hold", 76'(u_if.ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFD));
    check("div hold stallreq", 76'(u_if.stallreq_for_ex), 76'd0);
    run_div("div r", mk(4'd0, 32'hFFFF_FFF9, 32'd2, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0),
            32'hFFFF_FFFF);
    run_div("divu /0 q", mk(4'd0, 32'd7, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0),
            32'hFFFF_FFFF);
    run_div("divu /0 r", mk(4'd0, 32'd7, 32'd0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0),
            32'd7);
    run_div("div ovf", mk(4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0),
            32'h8000_0000);
    run_div("divu big", mk(4'd0, 32'hFFFF_FFFF, 32'h10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0),
            32'h0FFF_FFFF);
    run_div("divu rem", mk(4'd0, 32'd100, 32'd7, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0),
            32'd2);

    // Hold and bubble
    load(mk(4'd0, 32'd10, 32'd20, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    check("pre hold", 76'(u_if.ex_to_mem_bus[31:0]), 76'd30);
    u_if.id_to_ex_bus = mk(4'd2, 32'd1, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    u_if.stall = 6'b001111;
    step();
    check("hold bus", u_if.ex_to_mem_bus,
          {32'h0000_0100, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd7, 32'd30});
    u_if.stall = 6'b000111;
    step();
    check("bubble", u_if.ex_to_mem_bus, 76'd0);

    // Reset mid-divide, then a clean divide
    load(mk(4'd0, 32'd50, 32'd5, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0));
    u_if.stall = 6'b001111;
    for (int i = 0; i < 10; i++) step();
    check("busy stallreq", 76'(u_if.stallreq_for_ex), 76'd1);
    rst = 1'b0;
    #1;
    check("abort bus", u_if.ex_to_mem_bus, 76'd0);
    check("abort stallreq", 76'(u_if.stallreq_for_ex), 76'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("post rst", mk(4'd0, 32'd50, 32'd5, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0),
            32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
